// File: rtl/noc_link_buffer_pkg.sv
// Shared constants for the NoC link buffer: default flit widths, drop-injection LFSR seed/taps,
// and a saturating counter helper.
package noc_link_buffer_pkg;

    localparam int NOC_HEADER_SIZE_DEF  = 16;
    localparam int NOC_PAYLOAD_SIZE_DEF = 32;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/noc_link_lfsr16.sv
// 16-bit Fibonacci LFSR used for injected flit drops; loads its seed on reset and
// advances once per enabled cycle.
module noc_link_lfsr16
    import noc_link_buffer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb    = ^(r_state & LFSR_TAPS);
    assign o_state = r_state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= i_seed;
        end else if (i_en) begin
            r_state <= {r_state[14:0], w_fb};
        end
    end

endmodule

// File: rtl/noc_link_buffer.sv
// Elastic link buffer between the noc_arq tx side and the router, with skid-based stall,
// overflow drop and statistics. Drop injection is built only with NOC_LINK_DROP_INJECT_EN.
module noc_link_buffer
    import noc_link_buffer_pkg::*;
#(
    parameter int NOC_HEADER_SIZE  = NOC_HEADER_SIZE_DEF,
    parameter int NOC_PAYLOAD_SIZE = NOC_PAYLOAD_SIZE_DEF,
    parameter int FIFO_DEPTH       = 8,
    parameter int SKID             = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_q_i,
    input  logic                        wrreq_i,
    input  logic [NOC_HEADER_SIZE-1:0]  header_i,
    input  logic [NOC_PAYLOAD_SIZE-1:0] payload_i,
    output logic                        stall_o,
    output logic                        wrreq_o,
    output logic [NOC_HEADER_SIZE-1:0]  header_o,
    output logic [NOC_PAYLOAD_SIZE-1:0] payload_o,
    input  logic                        stall_i,
    input  logic [15:0]                 drop_thresh_i,
    output logic [31:0]                 flit_count_o,
    output logic [31:0]                 drop_count_o,
    output logic [31:0]                 ovf_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = NOC_HEADER_SIZE + NOC_PAYLOAD_SIZE;
    localparam logic [AW:0] STALL_LVL = (AW + 1)'(FIFO_DEPTH - SKID);

    logic [FW-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_stall;
    logic [31:0]   r_flit_cnt;
    logic [31:0]   r_ovf_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_ovf;
    logic          w_inj_drop;
    logic          w_push;
    logic [AW:0]   w_occ;
    logic [AW:0]   w_occ_next;
    logic [FW-1:0] w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop   = ~w_empty & ~stall_i;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign w_ovf   = wrreq_i & w_full & ~w_pop;
    assign w_push  = wrreq_i & ~w_ovf & ~w_inj_drop;

    assign w_occ      = r_wr_ptr - r_rd_ptr;
    assign w_occ_next = w_occ + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign header_o  = w_head[FW-1:NOC_PAYLOAD_SIZE];
    assign payload_o = w_head[NOC_PAYLOAD_SIZE-1:0];
    assign wrreq_o   = w_pop;
    assign stall_o   = r_stall;

    assign flit_count_o = r_flit_cnt;
    assign ovf_count_o  = r_ovf_cnt;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {header_i, payload_i};
        end
    end

    always_ff @(posedge clk_i or posedge reset_q_i) begin
        if (reset_q_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_stall    <= 1'b0;
            r_flit_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_flit_cnt <= sat_inc(r_flit_cnt);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_ovf) begin
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
            end
            r_stall <= (w_occ_next >= STALL_LVL);
        end
    end

`ifdef NOC_LINK_DROP_INJECT_EN
    logic        w_lfsr_en;
    logic [15:0] w_lfsr;
    logic [31:0] r_drop_cnt;

    // The LFSR only sees flits that survived the overflow check; compare uses the pre-advance value
    assign w_lfsr_en    = wrreq_i & ~w_ovf;
    assign w_inj_drop   = w_lfsr_en & (w_lfsr < drop_thresh_i);
    assign drop_count_o = r_drop_cnt;

    noc_link_lfsr16 u_lfsr (
        .i_clk   (clk_i),
        .i_rst   (reset_q_i),
        .i_en    (w_lfsr_en),
        .i_seed  (LFSR_SEED),
        .o_state (w_lfsr)
    );

    always_ff @(posedge clk_i or posedge reset_q_i) begin
        if (reset_q_i) begin
            r_drop_cnt <= '0;
        end else if (w_inj_drop) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end
`else
    logic w_unused_thresh;

    assign w_unused_thresh = ^drop_thresh_i;
    assign w_inj_drop      = 1'b0;
    assign drop_count_o    = '0;
`endif

endmodule

// File: tb/tb_noc_link_buffer.sv
// Self-checking bench for noc_link_buffer against a queue-based reference model;
// the drop-injection scenario follows NOC_LINK_DROP_INJECT_EN.
module tb_noc_link_buffer;

    localparam int HW = 16;
    localparam int PW = 32;
    localparam int D  = 8;
    localparam int SK = 2;

    logic          clk_i = 1'b0;
    logic          reset_q_i = 1'b0;
    logic          wrreq_i = 1'b0;
    logic [HW-1:0] header_i = '0;
    logic [PW-1:0] payload_i = '0;
    logic          stall_o;
    logic          wrreq_o;
    logic [HW-1:0] header_o;
    logic [PW-1:0] payload_o;
    logic          stall_i = 1'b0;
    logic [15:0]   drop_thresh_i = '0;
    logic [31:0]   flit_count_o;
    logic [31:0]   drop_count_o;
    logic [31:0]   ovf_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [HW+PW-1:0] m_q[$];
    int unsigned      m_flit, m_drop, m_ovf;
    logic             m_stall;
    logic [15:0]      m_lfsr;

    noc_link_buffer #(
        .NOC_HEADER_SIZE  (HW),
        .NOC_PAYLOAD_SIZE (PW),
        .FIFO_DEPTH       (D),
        .SKID             (SK)
    ) dut (
        .clk_i         (clk_i),
        .reset_q_i     (reset_q_i),
        .wrreq_i       (wrreq_i),
        .header_i      (header_i),
        .payload_i     (payload_i),
        .stall_o       (stall_o),
        .wrreq_o       (wrreq_o),
        .header_o      (header_o),
        .payload_o     (payload_o),
        .stall_i       (stall_i),
        .drop_thresh_i (drop_thresh_i),
        .flit_count_o  (flit_count_o),
        .drop_count_o  (drop_count_o),
        .ovf_count_o   (ovf_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] ref_lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_flit  = 0;
        m_drop  = 0;
        m_ovf   = 0;
        m_stall = 1'b0;
        m_lfsr  = 16'hACE1;
    endtask

    // Advance the model by one clock using the currently driven inputs, then move to edge+1.
    task automatic step();
        bit pop, drop;
        pop = (m_q.size() != 0) && !stall_i;
        if (pop) void'(m_q.pop_front());
        if (wrreq_i) begin
            if (m_q.size() == D) begin
                m_ovf++;
            end else begin
                drop = 1'b0;
`ifdef NOC_LINK_DROP_INJECT_EN
                drop   = (m_lfsr < drop_thresh_i);
                m_lfsr = ref_lfsr_next(m_lfsr);
`endif
                if (drop) m_drop++;
                else begin
                    m_q.push_back({header_i, payload_i});
                    m_flit++;
                end
            end
        end
        m_stall = (D - m_q.size()) <= SK;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        wrreq_i = 1'b0;
        stall_i = 1'b0;
        reset_q_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_q_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        n_tests++;
        if ({wrreq_o, stall_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: got wrreq_o/stall_o=%b%b want 00", wrreq_o, stall_o);
        end
        n_tests++;
        if ({flit_count_o, drop_count_o, ovf_count_o} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", flit_count_o, drop_count_o, ovf_count_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        header_i = 16'h0005;
        payload_i = $urandom;
        wrreq_i = 1'b1;
        step();
        wrreq_i = 1'b0;
        #2;
        n_tests++;
        if (wrreq_o !== 1'b1 || header_o !== 16'h0005 || {header_o, payload_o} !== m_q[0]) begin
            n_fail++;
            $display("FAIL single_out: got v=%b hdr=%h pl=%h want v=1 hdr=0005 pl=%h",
                     wrreq_o, header_o, payload_o, m_q[0][PW-1:0]);
        end
        step();
        #2;
        n_tests++;
        if (wrreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty: got wrreq_o=%b want 0", wrreq_o);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        stall_i = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            wrreq_i = 1'b1;
            header_i = HW'(i);
            payload_i = $urandom;
            step();
            if (i == 5 || i == 6) begin
                n_tests++;
                if (stall_o !== (i == 6)) begin
                    n_fail++;
                    $display("FAIL skid_stall push %0d: got stall_o=%b want %b", i, stall_o, (i == 6));
                end
            end
        end
        wrreq_i = 1'b0;
        n_tests++;
        if (ovf_count_o !== 32'd1 || flit_count_o !== 32'd8) begin
            n_fail++;
            $display("FAIL overflow_count: got ovf=%0d flits=%0d want ovf=1 flits=8", ovf_count_o, flit_count_o);
        end
        stall_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            #2;
            n_tests++;
            if (wrreq_o !== (i <= 8) || (i <= 8 && ({header_o, payload_o} !== m_q[0] || header_o !== HW'(i)))) begin
                n_fail++;
                $display("FAIL drain_order %0d: got v=%b hdr=%h want v=%b hdr=%h", i, wrreq_o, header_o, (i <= 8), HW'(i));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        stall_i = 1'b1;
        for (int i = 0; i < D; i++) begin
            wrreq_i = 1'b1;
            header_i = $urandom;
            payload_i = $urandom;
            step();
        end
        stall_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            header_i = $urandom;
            payload_i = $urandom;
            #2;
            n_tests++;
            if (wrreq_o !== 1'b1 || {header_o, payload_o} !== m_q[0]) begin
                n_fail++;
                $display("FAIL b2b_out cyc %0d: got v=%b data=%h want v=1 data=%h", i, wrreq_o, {header_o, payload_o}, m_q[0]);
            end
            step();
            n_tests++;
            if (stall_o !== 1'b1 || m_q.size() != D) begin
                n_fail++;
                $display("FAIL b2b_full cyc %0d: got stall_o=%b model_occ=%0d want 1/%0d", i, stall_o, m_q.size(), D);
            end
        end
        wrreq_i = 1'b0;
        n_tests++;
        if (ovf_count_o !== 32'd0 || flit_count_o !== 32'(m_flit)) begin
            n_fail++;
            $display("FAIL b2b_counts: got ovf=%0d flits=%0d want 0/%0d", ovf_count_o, flit_count_o, m_flit);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            wrreq_i = ($urandom_range(0, 3) != 0);
            stall_i = ($urandom_range(0, 2) == 0);
            header_i = $urandom;
            payload_i = $urandom;
            #2;
            n_tests++;
            if (wrreq_o !== (m_q.size() != 0 && !stall_i) ||
                (m_q.size() != 0 && {header_o, payload_o} !== m_q[0])) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL rnd_out cyc %0d: got v=%b data=%h want v=%b data=%h",
                                      i, wrreq_o, {header_o, payload_o}, (m_q.size() != 0 && !stall_i),
                                      (m_q.size() != 0) ? m_q[0] : '0);
            end
            step();
            n_tests++;
            if (stall_o !== m_stall) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL rnd_stall cyc %0d: got %b want %b", i, stall_o, m_stall);
            end
        end
        wrreq_i = 1'b0;
        n_tests++;
        if (flit_count_o !== 32'(m_flit) || ovf_count_o !== 32'(m_ovf)) begin
            n_fail++;
            $display("FAIL rnd_counts: got flits=%0d ovf=%0d want %0d/%0d", flit_count_o, ovf_count_o, m_flit, m_ovf);
        end
    endtask

    task automatic test_drop();
        int n_in, delivered, bad;
`ifdef NOC_LINK_DROP_INJECT_EN
        n_in = 1000;
        drop_thresh_i = 16'h8000;
`else
        n_in = 100;
        drop_thresh_i = 16'hFFFF;
`endif
        delivered = 0;
        bad = 0;
        do_reset();
        for (int i = 0; i <= n_in; i++) begin
            wrreq_i = (i < n_in);
            header_i = $urandom;
            payload_i = $urandom;
            #2;
            if (wrreq_o === 1'b1) delivered++;
            n_tests++;
            if (wrreq_o !== (m_q.size() != 0) || (m_q.size() != 0 && {header_o, payload_o} !== m_q[0])) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL drop_seq cyc %0d: got v=%b data=%h want v=%b", i, wrreq_o,
                                      {header_o, payload_o}, (m_q.size() != 0));
            end
            step();
        end
        wrreq_i = 1'b0;
        drop_thresh_i = '0;
        n_tests++;
        if (drop_count_o + flit_count_o !== 32'(n_in) || drop_count_o !== 32'(m_drop) || delivered != int'(m_flit)) begin
            n_fail++;
            $display("FAIL drop_totals: got drop=%0d flits=%0d delivered=%0d want drop=%0d flits=%0d",
                     drop_count_o, flit_count_o, delivered, m_drop, m_flit);
        end
`ifdef NOC_LINK_DROP_INJECT_EN
        n_tests++;
        if (drop_count_o < 32'd400 || drop_count_o > 32'd600) begin
            n_fail++;
            $display("FAIL drop_rate: got drop=%0d want 400..600", drop_count_o);
        end
`else
        n_tests++;
        if (delivered != 100 || drop_count_o !== 32'd0) begin
            n_fail++;
            $display("FAIL no_inject: got delivered=%0d drop=%0d want 100/0", delivered, drop_count_o);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wrreq_i = 1'b1;
            header_i = $urandom;
            payload_i = $urandom;
            step();
        end
        wrreq_i = 1'b0;
        stall_i = 1'b0;
        #1;
        reset_q_i = 1'b1;
        #1;
        n_tests++;
        if (wrreq_o !== 1'b0 || stall_o !== 1'b0 || flit_count_o !== 32'd0 || ovf_count_o !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b stall=%b flits=%0d ovf=%0d want 0/0/0/0",
                     wrreq_o, stall_o, flit_count_o, ovf_count_o);
        end
        @(posedge clk_i);
        #1;
        reset_q_i = 1'b0;
        model_reset();
        wrreq_i = 1'b1;
        header_i = 16'hBEEF;
        payload_i = $urandom;
        step();
        wrreq_i = 1'b0;
        #2;
        n_tests++;
        if (wrreq_o !== 1'b1 || header_o !== 16'hBEEF || {header_o, payload_o} !== m_q[0]) begin
            n_fail++;
            $display("FAIL post_reset_first: got v=%b hdr=%h want v=1 hdr=beef", wrreq_o, header_o);
        end
        step();
        #2;
        n_tests++;
        if (wrreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_empty: got wrreq_o=%b want 0", wrreq_o);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_random();
        test_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/noc_link_buffer.md
NOC_LINK_BUFFER -- requirements
Module: noc_link_buffer

Interface
REQ-001 SHALL have parameter NOC_HEADER_SIZE, default from noc_parameter.vh, header flit width.
REQ-002 SHALL have parameter NOC_PAYLOAD_SIZE, default from noc_parameter.vh, payload flit width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, flit entries; power of two, at least 4.
REQ-004 SHALL have parameter SKID, default 2, entries kept free when stall_o asserts.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port reset_q_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports wrreq_i, header_i, payload_i: inputs, 1/NOC_HEADER_SIZE/NOC_PAYLOAD_SIZE, flit from noc_arq NoC-side tx.
REQ-008 SHALL have port stall_o, output, 1, upstream stall.
REQ-009 SHALL have ports wrreq_o, header_o, payload_o: outputs, same widths, flit to router.
REQ-010 SHALL have port stall_i, input, 1, router stall.
REQ-011 SHALL have port drop_thresh_i, input, 16, injected-drop threshold; 0 means none.
REQ-012 SHALL have ports flit_count_o, drop_count_o, ovf_count_o: outputs, 32 each, statistics.

Function
REQ-013 SHALL accept a flit in every cycle with wrreq_i=1, regardless of stall_o.
REQ-014 SHALL drive stall_o as a register, set when free entries after this cycle's updates are <= SKID, else cleared.
REQ-015 SHALL drop a flit arriving when the FIFO is full, with no state change other than ovf_count_o+1.
REQ-016 SHALL present the head entry combinationally on header_o/payload_o; wrreq_o = !empty & !stall_i.
REQ-017 SHALL pop the head in each cycle wrreq_o=1; write-to-output latency is 1 cycle when empty and stall_i=0.
REQ-018 SHALL allow simultaneous push and pop when full; the push is accepted and occupancy stays FIFO_DEPTH.
REQ-019 SHALL use read/write pointers of log2(FIFO_DEPTH)+1 bits with wrap bit; full = equal index and differing wrap; empty = equal pointers.
REQ-020 SHALL preserve flit order; no reordering, no header inspection.
REQ-021 SHALL increment flit_count_o per accepted flit (after drop decision); all counters saturate at 0xFFFFFFFF.

Reset
REQ-022 SHALL on reset_q_i=1 clear pointers (empty), LFSR to 0xACE1, counters to 0, stall_o=0, wrreq_o=0.
REQ-023 SHALL discard buffered flits on reset mid-operation; no partial output after reset.

Configuration
REQ-024 SHALL implement drop injection only when macro NOC_LINK_DROP_INJECT_EN is defined.
REQ-025 With NOC_LINK_DROP_INJECT_EN: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per incoming flit not dropped for overflow; the flit is discarded, with drop_count_o+1, when the pre-advance LFSR value < drop_thresh_i.
REQ-026 Without NOC_LINK_DROP_INJECT_EN: no LFSR, drop_thresh_i ignored, drop_count_o tied to 0.

Structure
REQ-027 SHALL take flit widths from noc_parameter.vh; LFSR seed 0xACE1 and taps SHALL be defined as constants in that shared header.
REQ-028 SHALL instantiate one sub-module noc_link_lfsr16 (enable, seed, state out), only under the macro.
REQ-029 SHALL hold FIFO storage as a register array, no vendor RAM.

Verification
REQ-030 Reset; push 1 flit (header 0x5, stall_i=0) -> wrreq_o=1 next cycle, header_o=0x5, then empty.
REQ-031 stall_i=1, push 6 flits, FIFO_DEPTH=8, SKID=2 -> stall_o=1 the cycle after the 6th push; 8 pushes fill; 9th push -> ovf_count_o=1; release -> 8 flits in order.
REQ-032 Full, stall_i=0, push every cycle for 20 cycles -> zero overflows, occupancy 8, output order exact.
REQ-033 Macro defined, drop_thresh_i=0x8000, 1000 flits -> drop_count_o+flit_count_o=1000, drop_count_o in 400..600, sequence identical to the reference-model LFSR.
REQ-034 Assert reset_q_i with 5 flits buffered -> wrreq_o=0 and counters=0 immediately (async); first post-reset flit is the new one.
REQ-035 Macro undefined, drop_thresh_i=0xFFFF, 100 flits -> all 100 delivered, drop_count_o=0.
